processor_scheduler: RTL and testbench

//  Round-robin scheduler sharing one `processor` instance (a registered 2-input AND)

---
 rtl/processor_scheduler_pkg.sv | 14 +
 rtl/processor_scheduler_rr_pick.sv | 35 +++
 rtl/processor_scheduler.sv | 90 +++++++++
 tb/tb_processor_scheduler.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/processor_scheduler_pkg.sv
// Shared types for the round-robin processor scheduler.
// State encodings are fixed so processor-side blocks can decode them too.
package processor_scheduler_pkg;

  localparam int DEF_NUM_REQ = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_t;

endpackage

// File: rtl/processor_scheduler_rr_pick.sv
// Combinational round-robin pick: first set request after ptr, wrapping.
// Zero latency; no backpressure (pure function of req and ptr).
module processor_scheduler_rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] win_oh,
  output logic [IDX_W-1:0]   win_idx,
  output logic               any_req
);

  logic [IDX_W-1:0] cand;
  logic             found;

  // Scan starts one past the last winner so the previous winner is considered last.
  always_comb begin
    win_oh  = '0;
    win_idx = '0;
    cand    = '0;
    found   = 1'b0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = IDX_W'((int'(ptr) + i) % NUM_REQ);
      if (!found && req[cand]) begin
        found         = 1'b1;
        win_idx       = cand;
        win_oh[cand]  = 1'b1;
      end
    end
  end

  assign any_req = |req;

endmodule

// File: rtl/processor_scheduler.sv
// Round-robin sharing of one registered-AND processor among NUM_REQ requesters.
// Request-to-ack 3 cycles, one transaction per 4 cycles; losers simply keep req high.
module processor_scheduler
  import processor_scheduler_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [NUM_REQ-1:0] op_a_i,
  input  logic [NUM_REQ-1:0] op_b_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [NUM_REQ-1:0] ack_o,
  output logic               res_o,
  output logic               busy_o,
  output logic               proc_a_o,
  output logic               proc_b_o,
  input  logic               proc_res_i
);

  localparam int IDX_W = $clog2(NUM_REQ);

  state_t             state, state_nxt;
  logic [IDX_W-1:0]   ptr, pick_idx;
  logic [NUM_REQ-1:0] pick_oh, win_oh;
  logic               any_req, op_a, op_b, res;

  processor_scheduler_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .req     (req_i),
    .ptr     (ptr),
    .win_oh  (pick_oh),
    .win_idx (pick_idx),
    .any_req (any_req)
  );

  always_comb begin
    state_nxt = state;
    gnt_o     = '0;
    ack_o     = '0;
    proc_a_o  = 1'b0;
    proc_b_o  = 1'b0;
    busy_o    = 1'b1;
    case (state)
      IDLE: begin
        busy_o = 1'b0;
        if (any_req) state_nxt = ISSUE;
      end
      ISSUE, CAPTURE: begin
        gnt_o     = win_oh;
        proc_a_o  = op_a;
        proc_b_o  = op_b;
        state_nxt = (state == ISSUE) ? CAPTURE : DONE;
      end
      DONE: begin
        gnt_o     = win_oh;
        ack_o     = win_oh;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ptr resets to the top index so the first scan after reset starts at requester 0.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state  <= IDLE;
      ptr    <= IDX_W'(NUM_REQ - 1);
      win_oh <= '0;
      op_a   <= 1'b0;
      op_b   <= 1'b0;
      res    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && any_req) begin
        ptr    <= pick_idx;
        win_oh <= pick_oh;
        op_a   <= op_a_i[pick_idx];
        op_b   <= op_b_i[pick_idx];
      end
      if (state == CAPTURE) res <= proc_res_i;
    end
  end

  assign res_o = res;

endmodule

// File: tb/tb_processor_scheduler.sv
// Scoreboard bench for processor_scheduler with a registered-AND processor model.
module tb_processor_scheduler;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [3:0] req = '0;
  logic [3:0] op_a = '0;
  logic [3:0] op_b = '0;
  logic [3:0] gnt, ack;
  logic       res, busy, proc_a, proc_b, proc_res;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;

  typedef struct {
    logic [3:0] ack;
    logic       res;
    int         cyc;
  } sb_t;

  sb_t sb[$];
  sb_t e;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) proc_res <= proc_a & proc_b;

  processor_scheduler #(.NUM_REQ(4)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .req_i      (req),
    .op_a_i     (op_a),
    .op_b_i     (op_b),
    .gnt_o      (gnt),
    .ack_o      (ack),
    .res_o      (res),
    .busy_o     (busy),
    .proc_a_o   (proc_a),
    .proc_b_o   (proc_b),
    .proc_res_i (proc_res)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Every ack must match the oldest outstanding expectation, including its cycle.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && ack !== 4'b0000) begin
      if (sb.size() == 0) begin
        chk("spurious_ack", 32'(ack), 32'd0);
      end else begin
        e = sb.pop_front();
        chk("ack", 32'(ack), 32'(e.ack));
        chk("res", 32'(res), 32'(e.res));
        chk("ack_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  task automatic next_cycle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_ack(input int idx, input logic r, input int at);
    sb.push_back('{ack: 4'(1 << idx), res: r, cyc: at});
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    next_cycle(2);
    rst_n = 1'b1;
  endtask

  task automatic do_single(input int idx, input logic a, input logic b);
    logic [3:0] exp_gnt;
    exp_gnt = 4'(1 << idx);
    req = '0;  req[idx] = 1'b1;
    op_a = '0; op_a[idx] = a;
    op_b = '0; op_b[idx] = b;
    expect_ack(idx, a & b, cyc + 3);
    next_cycle(1);
    req = '0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      chk("single_gnt", 32'(gnt), 32'(exp_gnt));
      chk("single_proc_a", 32'(proc_a), 32'((k < 3) ? a : 1'b0));
      chk("single_proc_b", 32'(proc_b), 32'((k < 3) ? b : 1'b0));
    end
    next_cycle(1);
  endtask

  initial begin
    // Reset asserted mid-clock: outputs must clear without waiting for an edge.
    #27;
    rst_n = 1'b0;
    #1;
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_res", 32'(res), 32'd0);
    chk("rst_proc_a", 32'(proc_a), 32'd0);
    chk("rst_proc_b", 32'(proc_b), 32'd0);
    next_cycle(2);
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("idle_busy", 32'(busy), 32'd0);
    end
    next_cycle(1);

    do_single(0, 1'b1, 1'b1);
    do_single(0, 1'b1, 1'b0);

    // All four requesting: strict rotation from requester 0 after reset.
    do_reset();
    req = 4'b1111; op_a = 4'b1011; op_b = 4'b0111;
    expect_ack(0, 1'b1, cyc + 3);
    expect_ack(1, 1'b1, cyc + 7);
    expect_ack(2, 1'b0, cyc + 11);
    expect_ack(3, 1'b0, cyc + 15);
    expect_ack(0, 1'b1, cyc + 19);
    @(negedge clk);
    chk("busy_idle_cycle", 32'(busy), 32'd0);
    next_cycle(19);
    req = '0;
    next_cycle(2);

    // Requester 0 just served, so requester 2 must win first.
    do_single(0, 1'b1, 1'b1);
    req = 4'b0101; op_a = 4'b0100; op_b = 4'b0100;
    expect_ack(2, 1'b1, cyc + 3);
    expect_ack(0, 1'b0, cyc + 7);
    next_cycle(7);
    req = '0;
    next_cycle(2);

    // Reset during CAPTURE discards the op; the next scan restarts at requester 0.
    req = 4'b1110; op_a = 4'b1111; op_b = 4'b1111;
    next_cycle(2);
    @(negedge clk);
    chk("capture_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_gnt", 32'(gnt), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_proc_a", 32'(proc_a), 32'd0);
    req = 4'b1111; op_b = 4'b0001;
    next_cycle(2);
    rst_n = 1'b1;
    expect_ack(0, 1'b1, cyc + 3);
    next_cycle(1);
    req = '0;
    next_cycle(4);

    // Request dropped and operand toggled during ISSUE: latched operands win.
    req = 4'b0010; op_a = 4'b0010; op_b = 4'b0010;
    expect_ack(1, 1'b1, cyc + 3);
    next_cycle(1);
    req = '0; op_a = 4'b0000;
    @(negedge clk);
    chk("drop_gnt", 32'(gnt), 32'd2);
    chk("drop_proc_a", 32'(proc_a), 32'd1);
    next_cycle(5);

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
